// File: rtl/spi_peripheral_rx.sv
// Receive-only SPI Mode 0 peripheral: oversamples SCLK/COPI/CS_n on clk and delivers MSB-first bytes.
// Optional DC-bit capture alongside each byte when SPI_PERIPH_DC_CAPTURE_EN is defined.
`timescale 1ns/1ps

module spi_peripheral_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_copi,
    input  logic        spi_cs_n,
`ifdef SPI_PERIPH_DC_CAPTURE_EN
    input  logic        spi_dc,
    output logic        data_dc,
`endif
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        overrun,
    output logic        frame_error,
    output logic        frame_active,
    output logic [15:0] frame_bytes
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned FRAME_W = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Synchronisers reset to the idle pin levels so reset release never looks like an edge
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_hist;
    logic                   cs_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync   <= '0;
            copi_sync_r <= '0;
            cs_sync     <= '1;
            sclk_hist   <= 1'b0;
            cs_hist     <= 1'b1;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], spi_copi};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_hist   <= sclk_sync[SYNC_STAGES-1];
            cs_hist     <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic copi_s;
    logic cs_s;
    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync_r[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign cs_fall   = ~cs_s & cs_hist;
    assign cs_rise   = cs_s & ~cs_hist;

`ifdef SPI_PERIPH_DC_CAPTURE_EN
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   dc_s;
    logic                   data_dc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_sync <= '0;
            data_dc <= 1'b0;
        end else begin
            dc_sync <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
            data_dc <= data_dc_d;
        end
    end

    assign dc_s = dc_sync[SYNC_STAGES-1];
`endif

    logic [0:0]         state;
    logic [0:0]         state_d;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_d;
    logic [BYTE_W-2:0]  shreg;
    logic [BYTE_W-2:0]  shreg_d;
    logic [BYTE_W-1:0]  data_out_d;
    logic               data_valid_d;
    logic               overrun_d;
    logic               frame_error_d;
    logic               frame_active_d;
    logic [FRAME_W-1:0] frame_bytes_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            overrun      <= 1'b0;
            frame_error  <= 1'b0;
            frame_active <= 1'b0;
            frame_bytes  <= '0;
        end else begin
            state        <= state_d;
            bit_cnt      <= bit_cnt_d;
            shreg        <= shreg_d;
            data_out     <= data_out_d;
            data_valid   <= data_valid_d;
            overrun      <= overrun_d;
            frame_error  <= frame_error_d;
            frame_active <= frame_active_d;
            frame_bytes  <= frame_bytes_d;
        end
    end

    // Next-state: shifting, byte hand-off with overrun, and frame bookkeeping
    always_comb begin
        state_d        = state;
        bit_cnt_d      = bit_cnt;
        shreg_d        = shreg;
        data_out_d     = data_out;
        data_valid_d   = data_valid;
        overrun_d      = 1'b0;
        frame_error_d  = 1'b0;
        frame_active_d = frame_active;
        frame_bytes_d  = frame_bytes;
`ifdef SPI_PERIPH_DC_CAPTURE_EN
        data_dc_d      = data_dc;
`endif

        if (data_valid && data_ready) begin
            data_valid_d = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d        = ST_SHIFT;
                    bit_cnt_d      = '0;
                    shreg_d        = '0;
                    frame_bytes_d  = '0;
                    frame_active_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shreg_d   = {shreg[BYTE_W-3:0], copi_s};
                    bit_cnt_d = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                        if (frame_bytes != {FRAME_W{1'b1}}) begin
                            frame_bytes_d = frame_bytes + FRAME_W'(1);
                        end
                        if (!data_valid || data_ready) begin
                            data_out_d   = {shreg, copi_s};
                            data_valid_d = 1'b1;
`ifdef SPI_PERIPH_DC_CAPTURE_EN
                            data_dc_d    = dc_s;
`endif
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                // A byte completing on the same cycle as CS_n rise is not a framing error
                if (cs_rise) begin
                    state_d        = ST_IDLE;
                    frame_active_d = 1'b0;
                    frame_error_d  = (bit_cnt_d != '0);
                    bit_cnt_d      = '0;
                    shreg_d        = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_peripheral_rx.sv
// Scoreboard bench for spi_peripheral_rx: directed SPI frames, monitor pops expected bytes on each handshake.
`timescale 1ns/1ps

module tb_spi_peripheral_rx;

    localparam int unsigned HALF = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_copi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        dc_drv = 1'b0;
    logic        data_ready = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        overrun;
    logic        frame_error;
    logic        frame_active;
    logic [15:0] frame_bytes;
`ifdef SPI_PERIPH_DC_CAPTURE_EN
    logic        data_dc;
`endif

    spi_peripheral_rx #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk     (spi_sclk),
        .spi_copi     (spi_copi),
        .spi_cs_n     (spi_cs_n),
`ifdef SPI_PERIPH_DC_CAPTURE_EN
        .spi_dc       (dc_drv),
        .data_dc      (data_dc),
`endif
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .overrun      (overrun),
        .frame_error  (frame_error),
        .frame_active (frame_active),
        .frame_bytes  (frame_bytes)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;
    int valid_hi_cnt = 0;
    int valid_rise_cyc = -1;
    int t8 = 0;
    logic prev_valid = 1'b0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a byte is consumed on the edge after valid&ready is seen
    always @(negedge clk) begin
        logic [8:0] e;
        if (overrun) ovr_cnt++;
        if (frame_error) ferr_cnt++;
        if (data_valid) valid_hi_cnt++;
        if (data_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = data_valid;
        if (data_valid && data_ready && !rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got 0x%0h with nothing expected", data_out);
            end else begin
                e = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(e[7:0]));
`ifdef SPI_PERIPH_DC_CAPTURE_EN
                check("data_dc", 32'(data_dc), 32'(e[8]));
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits, input logic dc);
        for (int i = 0; i < nbits; i++) begin
            spi_copi = b[7-i];
            dc_drv   = dc;
            tick(HALF);
            spi_sclk = 1'b1;
            t8       = cyc;
            tick(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic start_frame();
        spi_cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic end_frame();
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(2 * HALF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, o0;

        // Reset values
        tick(3);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_error", 32'(frame_error), 32'h0);
        check("rst_frame_active", 32'(frame_active), 32'h0);
        check("rst_frame_bytes", 32'(frame_bytes), 32'h0);
        rst = 1'b0;
        tick(2);

        // Single byte 0xA5, latency and pulse width
        data_ready = 1'b1;
        valid_rise_cyc = -1;
        v0 = valid_hi_cnt;
        exp_q.push_back({1'b0, 8'hA5});
        start_frame();
        check("frame_active_on", 32'(frame_active), 32'h1);
        send_byte(8'hA5, 8, 1'b0);
        check("valid_latency", 32'(valid_rise_cyc - t8), 32'd3);
        check("valid_width", 32'(valid_hi_cnt - v0), 32'd1);
        end_frame();
        check("a5_frame_bytes", 32'(frame_bytes), 32'd1);
        check("a5_frame_error", 32'(ferr_cnt), 32'd0);
        check("a5_frame_active_off", 32'(frame_active), 32'h0);

        // Three back-to-back bytes
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'h3C});
        start_frame();
        send_byte(8'h00, 8, 1'b0);
        send_byte(8'hFF, 8, 1'b0);
        send_byte(8'h3C, 8, 1'b0);
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(2);
        check("fa_still_high", 32'(frame_active), 32'h1);
        tick(1);
        check("fa_fall_latency", 32'(frame_active), 32'h0);
        tick(HALF);
        check("three_frame_bytes", 32'(frame_bytes), 32'd3);
        check("three_queue_drained", 32'(exp_q.size()), 32'd0);

        // Overrun with consumer stalled
        data_ready = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back({1'b0, 8'h11});
        start_frame();
        send_byte(8'h11, 8, 1'b0);
        send_byte(8'h22, 8, 1'b0);
        end_frame();
        check("ovr_data_out", 32'(data_out), 32'h11);
        check("ovr_data_valid", 32'(data_valid), 32'h1);
        check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_frame_bytes", 32'(frame_bytes), 32'd2);
        data_ready = 1'b1;
        tick(3);
        check("ovr_queue_drained", 32'(exp_q.size()), 32'd0);

        // Frame error after 5 bits, then a clean frame
        f0 = ferr_cnt;
        v0 = valid_hi_cnt;
        start_frame();
        send_byte(8'hF0, 5, 1'b0);
        end_frame();
        check("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_no_valid", 32'(valid_hi_cnt - v0), 32'd0);
        exp_q.push_back({1'b0, 8'h81});
        start_frame();
        send_byte(8'h81, 8, 1'b0);
        end_frame();
        check("after_ferr_data_out", 32'(data_out), 32'h81);
        check("after_ferr_no_new_err", 32'(ferr_cnt - f0), 32'd1);

        // Reset in the middle of a byte
        start_frame();
        send_byte(8'hC3, 4, 1'b0);
        rst = 1'b1;
        spi_cs_n = 1'b1;
        tick(2);
        check("midrst_data_out", 32'(data_out), 32'h0);
        check("midrst_data_valid", 32'(data_valid), 32'h0);
        check("midrst_frame_active", 32'(frame_active), 32'h0);
        check("midrst_frame_bytes", 32'(frame_bytes), 32'h0);
        rst = 1'b0;
        tick(5);
        exp_q.push_back({1'b0, 8'h5A});
        start_frame();
        send_byte(8'h5A, 8, 1'b0);
        end_frame();
        check("postrst_data_out", 32'(data_out), 32'h5A);
        check("postrst_frame_bytes", 32'(frame_bytes), 32'd1);

`ifdef SPI_PERIPH_DC_CAPTURE_EN
        // DC bit travels with its byte
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'h12});
        start_frame();
        send_byte(8'h2A, 8, 1'b0);
        send_byte(8'h12, 8, 1'b1);
        end_frame();
`endif

        tick(4);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
